// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage
// and a multi-cycle, ack-based line memory. Hits complete in the request cycle;
// misses stall, optionally write back the dirty victim, refill, then complete.
module dcache_controller #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned TAG_W   = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned OFS_W  = $clog2(LINE_W / 8);
  localparam int unsigned WORDS  = LINE_W / WORD_W;
  localparam int unsigned WSEL_W = $clog2(WORDS);

  typedef logic [WORDS-1:0][WORD_W-1:0] line_t;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;

  state_t             state;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] dirty;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  line_t              line_mem [ENTRIES];

  logic [IDX_W-1:0]  idx_c;
  logic [TAG_W-1:0]  tag_c;
  logic [WSEL_W-1:0] word_c;
  logic              req_c;
  logic              hit_c;
  line_t             cur_line_c;
  logic              unused_c;

  // Address decode and hit detection
  assign idx_c      = p1_addr_i[OFS_W +: IDX_W];
  assign tag_c      = p1_addr_i[31 -: TAG_W];
  assign word_c     = p1_addr_i[2 +: WSEL_W];
  assign unused_c   = ^p1_addr_i[1:0];
  assign req_c      = p1_MemRead_i | p1_MemWrite_i;
  assign hit_c      = valid[idx_c] & (tag_mem[idx_c] == tag_c);
  assign cur_line_c = line_mem[idx_c];

  // Load data shows the stored (pre-store) word; stall covers misses and any busy state
  assign p1_data_o  = (p1_MemRead_i & hit_c) ? cur_line_c[word_c] : '0;
  assign p1_stall_o = (req_c & ~hit_c) | (state != IDLE);

  // Miss FSM, per-line valid/dirty bits and registered memory request outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      mem_enable_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_c & ~hit_c) begin
            state <= MISS;
          end else if (p1_MemWrite_i & hit_c) begin
            dirty[idx_c] <= 1'b1;
          end
        end
        MISS: begin
          mem_enable_o <= 1'b1;
          if (valid[idx_c] & dirty[idx_c]) begin
            state       <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_mem[idx_c], idx_c, OFS_W'(0)};
            mem_data_o  <= cur_line_c;
          end else begin
            state       <= READMISS;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag_c, idx_c, OFS_W'(0)};
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state        <= READMISS;
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {tag_c, idx_c, OFS_W'(0)};
          end
        end
        READMISS: begin
          if (mem_ack_i) begin
            state        <= READMISSOK;
            valid[idx_c] <= 1'b1;
            dirty[idx_c] <= 1'b0;
          end
        end
        READMISSOK: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Tag and line storage: refill on ack, word merge on a store hit in IDLE
  always_ff @(posedge clk_i) begin
    if ((state == READMISS) && mem_ack_i) begin
      tag_mem[idx_c]  <= tag_c;
      line_mem[idx_c] <= mem_data_i;
    end else if ((state == IDLE) && p1_MemWrite_i && hit_c) begin
      line_mem[idx_c][word_c] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a cycle-stepped access task plays the
// memory side (ack L cycles after each enable pulse) and records request pulses.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int checks = 0;
  int errors = 0;

  // Request pulses captured during the last access
  int           pulse_n;
  logic [31:0]  pulse_addr [2];
  logic         pulse_wr   [2];
  logic [255:0] pulse_data [2];

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory content: word w of line a is {C0DE, a[15:0]+w}
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {16'hC0DE, a[15:0] + 16'(w)};
    return l;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One CPU access held until stall drops; returns stall cycles and the data seen
  // in the completing cycle. Called and returns at posedge+1.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input int lat,
                           output int stalls, output logic [31:0] rdata);
    int ack_at;
    int cyc;
    logic [31:0] req_addr;
    p1_addr_i     = addr;
    p1_data_i     = data;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    pulse_n  = 0;
    ack_at   = -1;
    cyc      = 0;
    stalls   = 0;
    req_addr = '0;
    forever begin
      mem_ack_i  = (cyc == ack_at);
      mem_data_i = mem_ack_i ? mem_line(req_addr) : '0;
      #1;
      if (mem_enable_o) begin
        if (pulse_n < 2) begin
          pulse_addr[pulse_n] = mem_addr_o;
          pulse_wr[pulse_n]   = mem_write_o;
          pulse_data[pulse_n] = mem_data_o;
        end
        pulse_n++;
        req_addr = mem_addr_o;
        ack_at   = cyc + lat;
      end
      if (!p1_stall_o) break;
      stalls++;
      if (cyc > 300) begin
        chk("access_timeout", 32'(cyc), 32'd0);
        break;
      end
      step();
      cyc++;
    end
    rdata = p1_data_o;
    step();
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    mem_ack_i     = 1'b0;
    mem_data_i    = '0;
  endtask

  initial begin
    int          st;
    int          n;
    logic [31:0] rd;

    rst_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
    step();

    // Reset state
    chk("rst_stall",  32'(p1_stall_o),   32'd0);
    chk("rst_enable", 32'(mem_enable_o), 32'd0);
    chk("rst_write",  32'(mem_write_o),  32'd0);
    chk("rst_addr",   mem_addr_o,        32'd0);
    chk("rst_data",   p1_data_o,         32'd0);

    // Clean load miss, L=10
    do_access(1'b1, 1'b0, 32'h40, 32'd0, 10, st, rd);
    chk("ld40_stall",  32'(st),        32'd14);
    chk("ld40_pulses", 32'(pulse_n),   32'd1);
    chk("ld40_addr",   pulse_addr[0],  32'h40);
    chk("ld40_wr",     32'(pulse_wr[0]), 32'd0);
    chk("ld40_data",   rd,             32'hC0DE0040);

    // Hits: reload, store, load back
    do_access(1'b1, 1'b0, 32'h40, 32'd0, 10, st, rd);
    chk("hit40_stall", 32'(st), 32'd0);
    chk("hit40_data",  rd,      32'hC0DE0040);
    do_access(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 10, st, rd);
    chk("st44_stall",  32'(st), 32'd0);
    do_access(1'b1, 1'b0, 32'h44, 32'd0, 10, st, rd);
    chk("ld44_stall",  32'(st), 32'd0);
    chk("ld44_data",   rd,      32'hDEADBEEF);
    chk("dirty2",      32'(dut.dirty[2]), 32'd1);

    // Dirty conflict miss, L=10: write-back then refill
    do_access(1'b1, 1'b0, 32'h440, 32'd0, 10, st, rd);
    chk("ld440_stall",  32'(st),          32'd25);
    chk("ld440_pulses", 32'(pulse_n),     32'd2);
    chk("wb_wr",        32'(pulse_wr[0]), 32'd1);
    chk("wb_addr",      pulse_addr[0],    32'h40);
    chk("wb_word1",     pulse_data[0][63:32], 32'hDEADBEEF);
    chk("wb_word0",     pulse_data[0][31:0],  32'hC0DE0040);
    chk("rf_wr",        32'(pulse_wr[1]), 32'd0);
    chk("rf_addr",      pulse_addr[1],    32'h440);
    chk("ld440_data",   rd,               32'hC0DE0440);

    // Store miss on clean line, L=3: refill then merge
    do_access(1'b0, 1'b1, 32'h80, 32'h1234, 3, st, rd);
    chk("st80_stall", 32'(st),        32'd7);
    chk("st80_addr",  pulse_addr[0],  32'h80);
    chk("st80_wr",    32'(pulse_wr[0]), 32'd0);
    do_access(1'b1, 1'b0, 32'h80, 32'd0, 3, st, rd);
    chk("ld80_stall", 32'(st), 32'd0);
    chk("ld80_data",  rd,      32'h1234);
    chk("dirty4",     32'(dut.dirty[4]), 32'd1);

    // Reset during READMISS, then a stray ack
    p1_addr_i = 32'h40; p1_MemRead_i = 1'b1;
    n = 0;
    while (!mem_enable_o && n < 20) begin step(); n++; end
    chk("mr_pulse",    32'(mem_enable_o), 32'd1);
    chk("mr_pulse_at", 32'(n),            32'd2);
    step();
    rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    #1;
    chk("mr_rst_enable", 32'(mem_enable_o), 32'd0);
    chk("mr_rst_addr",   mem_addr_o,        32'd0);
    step();
    rst_i = 1'b1;
    step();
    mem_ack_i = 1'b1; mem_data_i = mem_line(32'h40);
    step();
    mem_ack_i = 1'b0; mem_data_i = '0;
    #1;
    chk("mr_stall", 32'(p1_stall_o), 32'd0);
    chk("mr_valid", 32'(dut.valid),  32'd0);
    do_access(1'b1, 1'b0, 32'h40, 32'd0, 2, st, rd);
    chk("mr_reload_stall", 32'(st), 32'd6);
    chk("mr_reload_data",  rd,      32'hC0DE0040);

    // Read and write together on a hit: old word visible, store commits
    do_access(1'b1, 1'b1, 32'h40, 32'h5555AAAA, 2, st, rd);
    chk("rw_stall", 32'(st), 32'd0);
    chk("rw_old",   rd,      32'hC0DE0040);
    do_access(1'b1, 1'b0, 32'h40, 32'd0, 2, st, rd);
    chk("rw_new",   rd,      32'h5555AAAA);

    // Dirty miss with minimum latency L=1
    do_access(1'b1, 1'b0, 32'h440, 32'd0, 1, st, rd);
    chk("l1_stall",  32'(st),          32'd7);
    chk("l1_wb_wr",  32'(pulse_wr[0]), 32'd1);
    chk("l1_wb_w0",  pulse_data[0][31:0], 32'h5555AAAA);
    chk("l1_rf_adr", pulse_addr[1],    32'h440);
    chk("l1_data",   rd,               32'hC0DE0440);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache placed between the pipelined CPU's MEM stage and an off-chip data memory with a multi-cycle, acknowledge-based line interface. It answers CPU loads/stores in the same cycle on a hit. On a miss it asserts a stall, writes back a dirty victim if needed, refills the line, then completes the access.

## Interface
- ENTRIES, 32: number of cache lines; index width = log2(ENTRIES) = 5.
- LINE_W, 256: line width in bits (32 bytes, 8 words); offset width 5.
- TAG_W, 22: tag width = 32 − 5 − 5; addr[31:10].
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- p1_addr_i  in  32  CPU byte address; word select = addr[4:2], index = addr[9:5], tag = addr[31:10].
- p1_data_i  in  32  CPU store data.
- p1_MemRead_i  in  1  load request, level.
- p1_MemWrite_i  in  1  store request, level.
- p1_data_o  out  32  load data, combinational on hit.
- p1_stall_o  out  1  freeze request to pipeline.
- mem_addr_o  out  32  line address, addr[4:0] = 0.
- mem_data_o  out  LINE_W  victim line for write-back.
- mem_enable_o  out  1  one-cycle request pulse.
- mem_write_o  out  1  1 = write-back, 0 = refill; valid with mem_enable_o.
- mem_data_i  in  LINE_W  refill line, valid when mem_ack_i = 1.
- mem_ack_i  in  1  one-cycle completion pulse.

## Operation
- Per-entry state: valid, dirty, tag, line.
- req = MemRead | MemWrite. hit = valid[idx] & (tag[idx] == addr tag).
- If both MemRead and MemWrite are high, the store takes effect. p1_data_o still shows the pre-store word.
- Read hit: p1_data_o = line[idx] word addr[4:2]. Otherwise p1_data_o = 0.
- Write hit (IDLE, stall low): at the clock edge, replace the selected word with p1_data_i and set dirty = 1.
- p1_stall_o = (req & ~hit) | (state != IDLE).
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
  - IDLE → MISS when req & ~hit.
  - MISS → WRITEBACK if valid & dirty. Issue an enable pulse with write = 1, addr = {old tag, idx, 5'b0}, data = old line.
  - MISS → READMISS otherwise. Issue an enable pulse with write = 0, addr = {new tag, idx, 5'b0}.
  - WRITEBACK: wait for mem_ack_i, then → READMISS and issue the refill pulse.
  - READMISS: on mem_ack_i, load the line from mem_data_i with valid = 1, dirty = 0, tag = new tag; → READMISSOK.
  - READMISSOK → IDLE. The access then hits, and a pending store merges on that IDLE edge.
- The CPU holds addr, data and requests stable while stalled.
- mem_ack_i outside WRITEBACK/READMISS is ignored.
- Reset, including mid-miss: state = IDLE, all valid = 0, all dirty = 0, outputs 0. An outstanding transaction is abandoned and any late ack is ignored.

## Timing
- Hit: zero stall cycles; the store commits at the end of the request cycle.
- Enable pulse: registered, high exactly during the first cycle of WRITEBACK or READMISS. mem_write_o and mem_addr_o are held for the whole state.
- Memory latency L ≥ 1: ack arrives L cycles after the enable cycle.
- Clean miss: stall high for L + 4 cycles, measured from the request cycle C. Stall is low in cycle C + L + 4, where the access completes.
- Dirty miss: stall high for 2L + 5 cycles.
- An ack in the same cycle as the enable pulse is not legal.
- No back-to-back stall bubble after READMISSOK; the next new request is evaluated in that IDLE cycle.

## Test plan
- Reset, then load 0x0000_0040 with L = 10: the refill pulse is seen with mem_addr_o = 0x40 and write = 0. Stall is high for 14 cycles, then p1_data_o = word 0 of the returned line.
- Repeat the load of 0x40, then store 0xDEADBEEF to 0x44: zero stall. A following load of 0x44 returns 0xDEADBEEF and dirty[2] = 1.
- Load 0x0000_0440 (same index 2, new tag):
  - First a write-back pulse, write = 1, addr = 0x40, with a mem_data_o word 1 of 0xDEADBEEF.
  - Then a refill at 0x440; stall is high for 25 cycles.
- Store to a missing clean line 0x80 with data 0x1234: refill, then merge. A later load of 0x80 returns 0x1234 with no stall, and dirty = 1.
- Assert rst_i low during READMISS, then give a stray ack after reset release: state stays IDLE, valid is all 0, and the next load of 0x40 misses again.
- Assert MemRead and MemWrite together on a hit: the store commits and p1_data_o shows the old word in that cycle.
